// File: rtl/zl_deinterleaver_pkg.sv
// Shared DVB convolutional (de)interleaver parameters and deinterleaver pipeline types.
package zl_deinterleaver_pkg;

  localparam int unsigned DVB_I        = 12;
  localparam int unsigned DVB_M        = 17;
  localparam int unsigned DVB_PKT_LEN  = 204;
  localparam logic [7:0]  DVB_SYNC     = 8'h47;
  localparam logic [7:0]  DVB_SYNC_INV = 8'hB8;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ARM_W      = 4;
  localparam int unsigned PTR_W      = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned RAM_AW     = ARM_W + PTR_W;
  localparam int unsigned FIFO_DEPTH = 4;

  // One in-flight RAM read; byp selects the captured input byte over RAM data.
  typedef struct packed {
    logic              valid;
    logic              byp;
    logic [BYTE_W-1:0] data;
  } rd_pipe_t;

  // Write-pointer lead over read pointer for a deinterleaver arm.
  function automatic logic [PTR_W-1:0] arm_delay(input int unsigned arm);
    return PTR_W'(DVB_M * (DVB_I - 1 - arm));
  endfunction

endpackage

// File: rtl/zl_fifo_sc.sv
// Single-clock FIFO, power-of-two depth, show-ahead output.
module zl_fifo_sc #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/zl_sdp_ram.sv
// Simple-dual-port RAM, read-old-data on collision, 2-cycle registered read latency.
module zl_sdp_ram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [1<<AW];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] rdata_q;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rd_q    <= mem_q[raddr_i];
    rdata_q <= rd_q;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/zl_deinterleaver.sv
// DVB convolutional deinterleaver (I=12, M=17): per-arm circular buffers in one RAM,
// sync-byte alignment, token/data FIFOs for req/ack flow control.
module zl_deinterleaver
  import zl_deinterleaver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in_req,
  output logic       data_in_ack,
  input  logic [7:0] data_in,
  output logic       data_out_req,
  input  logic       data_out_ack,
  output logic [7:0] data_out,
  output logic       locked
);

  logic [ARM_W-1:0]  arm_q, arm_d, arm_sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic [PTR_W-1:0]  rd_ptr_q [DVB_I];
  logic [PTR_W-1:0]  rd_ptr_d [DVB_I];
  logic [PTR_W-1:0]  wr_ptr_q [DVB_I];
  logic [PTR_W-1:0]  wr_ptr_d [DVB_I];
  rd_pipe_t          pipe1_q, pipe1_d, pipe2_q;

  logic              acc, sop, is_sync, resync;
  logic [RAM_AW-1:0] waddr, raddr;
  logic [BYTE_W-1:0] ram_rdata, out_byte;
  logic              tok_full, tok_empty, tok_flag;
  logic              dat_full, dat_empty, dat_push, out_pop;

  // The token FIFO reserves an output slot per accepted byte, so the data FIFO never overflows.
  assign data_in_ack = data_in_req & ~tok_full;
  assign acc         = data_in_ack;
  assign sop         = (cnt_q == '0);
  assign is_sync     = (data_in == DVB_SYNC) || (data_in == DVB_SYNC_INV);
  assign resync      = acc & sop & ~is_sync;
  assign arm_sel     = resync ? '0 : arm_q;
  assign waddr       = {arm_sel, wr_ptr_q[arm_sel]};
  assign raddr       = {arm_sel, rd_ptr_q[arm_sel]};

  always_comb begin
    arm_d         = arm_q;
    cnt_d         = cnt_q;
    locked_d      = locked_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pipe1_d.valid = acc;
    pipe1_d.byp   = acc & (waddr == raddr);
    pipe1_d.data  = data_in;
    if (acc) begin
      if (resync) begin
        // Missing sync at packet start: hold alignment and wait for the next sync byte.
        arm_d    = '0;
        locked_d = 1'b0;
      end else begin
        locked_d          = locked_q | sop;
        rd_ptr_d[arm_sel] = rd_ptr_q[arm_sel] + PTR_W'(1);
        wr_ptr_d[arm_sel] = wr_ptr_q[arm_sel] + PTR_W'(1);
        arm_d             = (arm_q == ARM_W'(DVB_I - 1)) ? '0 : arm_q + ARM_W'(1);
        cnt_d             = (cnt_q == CNT_W'(DVB_PKT_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      pipe1_q  <= '0;
      pipe2_q  <= '0;
      for (int unsigned i = 0; i < DVB_I; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= arm_delay(i);
      end
    end else begin
      arm_q    <= arm_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      pipe1_q  <= pipe1_d;
      pipe2_q  <= pipe1_q;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  zl_sdp_ram #(
    .AW (RAM_AW),
    .DW (BYTE_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (acc),
    .waddr_i (waddr),
    .wdata_i (data_in),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  assign out_byte     = pipe2_q.byp ? pipe2_q.data : ram_rdata;
  assign dat_push     = pipe2_q.valid & ~dat_full;
  assign data_out_req = tok_flag & ~tok_empty & ~dat_empty;
  assign out_pop      = data_out_req & data_out_ack;
  assign locked       = locked_q;

  zl_fifo_sc #(
    .DW    (1),
    .DEPTH (FIFO_DEPTH)
  ) u_tok_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (acc),
    .data_i  (1'b1),
    .pop_i   (out_pop),
    .data_o  (tok_flag),
    .empty_o (tok_empty),
    .full_o  (tok_full)
  );

  zl_fifo_sc #(
    .DW    (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_dat_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (dat_push),
    .data_i  (out_byte),
    .pop_i   (out_pop),
    .data_o  (data_out),
    .empty_o (dat_empty),
    .full_o  (dat_full)
  );

endmodule

// File: tb/tb_zl_deinterleaver.sv
// Randomized bench for zl_deinterleaver against a per-arm delay-queue reference model.
module tb_zl_deinterleaver;

  localparam int NPKT_LB = 50;
  localparam int LB_N    = NPKT_LB * 204;
  localparam int E2E     = 2244;

  logic       clk;
  logic       rst_n;
  logic       data_in_req;
  logic       data_in_ack;
  logic [7:0] data_in;
  logic       data_out_req;
  logic       data_out_ack;
  logic [7:0] data_out;
  logic       locked;

  zl_deinterleaver dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_req  (data_in_req),
    .data_in_ack  (data_in_ack),
    .data_in      (data_in),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .data_out     (data_out),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Reference model: arm i is a FIFO of 17*(11-i) bytes; -1 marks unknown RAM content.
  int m_q [12][$];
  int m_arm, m_cnt;
  int m_locked;
  int exp_q [$];
  int stim_q [$];
  int il_q [12][$];
  int src [LB_N];
  int out_idx;
  bit lb_on;
  bit acc_in;
  bit out_seen;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_q[i].delete();
      repeat (17 * (11 - i)) m_q[i].push_back(-1);
    end
    m_arm = 0;
    m_cnt = 0;
    m_locked = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int b);
    int v;
    if (m_cnt == 0 && b != 8'h47 && b != 8'hB8) begin
      m_locked = 0;
      m_arm = 0;
      v = m_q[0][0];
    end else begin
      if (m_cnt == 0) m_locked = 1;
      m_q[m_arm].push_back(b);
      v = m_q[m_arm].pop_front();
      m_arm = (m_arm + 1) % 12;
      m_cnt = (m_cnt + 1) % 204;
    end
    exp_q.push_back(v);
  endtask

  // req_mode/ack_mode: 0 = low, 1 = high, 2 = random.
  task automatic cycle(input int req_mode, input int ack_mode);
    int v;
    @(posedge clk);
    #1;
    data_in_req  = (stim_q.size() > 0) &&
                   (req_mode == 1 || (req_mode == 2 && $urandom_range(0, 9) < 8));
    data_in      = (stim_q.size() > 0) ? 8'(stim_q[0]) : 8'h00;
    data_out_ack = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(0, 9) < 7);
    #1;
    chk("locked", locked, m_locked);
    acc_in   = data_in_req && data_in_ack;
    out_seen = data_out_req;
    if (data_out_req && data_out_ack) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        v = exp_q.pop_front();
        if (v >= 0) chk("data_out", data_out, v);
        if (lb_on && out_idx >= E2E && out_idx < LB_N)
          chk("loopback", data_out, src[out_idx - E2E]);
        out_idx++;
      end
    end
    if (acc_in) begin
      model_accept(stim_q[0]);
      void'(stim_q.pop_front());
    end
  endtask

  task automatic run_stim(input int budget);
    int k;
    k = 0;
    while (stim_q.size() > 0 && k < budget) begin
      cycle(2, 2);
      k++;
    end
    chk("stim_drained", stim_q.size(), 0);
  endtask

  task automatic push_pkt(input int sync);
    stim_q.push_back(sync);
    repeat (203) stim_q.push_back(int'($urandom_range(0, 255)));
  endtask

  initial begin
    int lat, n, k;
    bit found;
    clk = 1'b0;
    rst_n = 1'b0;
    data_in_req = 1'b0;
    data_in = 8'h00;
    data_out_ack = 1'b0;
    n_chk = 0;
    n_pass = 0;
    out_idx = 0;
    lb_on = 1'b1;
    model_reset();

    // Loopback source: sync + incrementing count, through a behavioural interleaver.
    for (int i = 0; i < 12; i++) begin
      il_q[i].delete();
      repeat (17 * i) il_q[i].push_back(int'($urandom_range(0, 255)));
    end
    for (int j = 0; j < LB_N; j++) begin
      src[j] = (j % 204 == 0) ? 8'h47 : (j & 255);
      il_q[j % 12].push_back(src[j]);
      stim_q.push_back(il_q[j % 12].pop_front());
    end

    #1;
    chk("rst_out_req", data_out_req, 0);
    chk("rst_in_ack", data_in_ack, 0);
    chk("rst_locked", locked, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Latency from ack to data_out_req with empty FIFOs.
    cycle(1, 1);
    chk("first_ack", acc_in, 1);
    lat = 0;
    found = 1'b0;
    for (int j = 0; j < 8 && !found; j++) begin
      cycle(0, 1);
      lat++;
      found = out_seen;
    end
    chk("latency", lat, 3);

    // Full rate with downstream always ready.
    n = 0;
    repeat (40) begin
      cycle(1, 1);
      n += int'(acc_in);
    end
    chk("throughput", n, 40);

    // Backpressure: only the 4 FIFO slots may be accepted.
    repeat (6) cycle(0, 1);
    n = 0;
    repeat (20) begin
      cycle(1, 0);
      n += int'(acc_in);
    end
    chk("bp_acks", n, 4);
    chk("bp_out_req", out_seen, 1);

    run_stim(60000);
    cycle(0, 2);
    chk("loopback_locked", locked, 1);

    // Sync loss, re-lock, inverted sync.
    stim_q.push_back(8'h00);
    stim_q.push_back(8'h00);
    run_stim(200);
    cycle(0, 2);
    chk("sync_loss_locked", locked, 0);
    push_pkt(8'h47);
    push_pkt(8'hB8);
    push_pkt(8'h47);
    push_pkt(8'h47);
    run_stim(5000);
    cycle(0, 2);
    chk("relock", locked, 1);

    // Reset mid-packet.
    push_pkt(8'h47);
    push_pkt(8'h47);
    push_pkt(8'h47);
    repeat (300) cycle(2, 2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    data_in_req = 1'b0;
    data_out_ack = 1'b0;
    #1;
    chk("mid_rst_out_req", data_out_req, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_in_ack", data_in_ack, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    lb_on = 1'b0;
    stim_q.delete();
    model_reset();
    repeat (12) push_pkt(8'h47);
    run_stim(20000);

    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      cycle(0, 1);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
    cycle(0, 1);
    chk("final_out_req", data_out_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
